// File: rtl/edge_ts_pkg.sv
// Shared definitions for the edge timestamp path: the edge type encoding
// and the layout of an event word {edge_type, timestamp}.
package edge_ts_pkg;

  localparam logic EDGE_RISE = 1'b1;
  localparam logic EDGE_FALL = 1'b0;

  // The timestamp occupies the low bits and the edge type sits directly above it.
  localparam int EV_TS_LSB = 0;

  function automatic int ev_width(input int ts_width);
    return ts_width + 1;
  endfunction

  function automatic int ev_type_bit(input int ts_width);
    return ts_width;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO: the head entry is visible on
// rdata whenever the FIFO is non-empty. A push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never reset; stale words are hidden by the empty gate below.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = empty ? '0 : mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/edge_timestamp_fifo.sv
// Detects enabled rising/falling edges, tags them with a free-running cycle
// timestamp and queues them for readout; counts edges lost to a full queue.
module edge_timestamp_fifo
  import edge_ts_pkg::*;
#(
  parameter int TS_WIDTH   = 32,
  parameter int DEPTH      = 8,
  parameter int DROP_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sig,
  input  logic                       delayed_sig,
  input  logic                       rise_en,
  input  logic                       fall_en,
  output logic                       ev_valid,
  input  logic                       ev_ready,
  output logic [TS_WIDTH:0]          ev_data,
  output logic [$clog2(DEPTH):0]     ev_count,
  output logic                       overflow,
  output logic [DROP_WIDTH-1:0]      drop_count,
  input  logic                       clr_stats
);

  localparam int EW = ev_width(TS_WIDTH);
  localparam int TB = ev_type_bit(TS_WIDTH);

  logic                  armed_q;
  logic [TS_WIDTH-1:0]   ts_q;
  logic                  overflow_q, overflow_d;
  logic [DROP_WIDTH-1:0] drop_count_q, drop_count_d;

  logic          rise, fall, edge_req, push, pop, drop;
  logic          fifo_full, fifo_empty;
  logic [EW-1:0] wdata;

  assign rise     = sig & ~delayed_sig;
  assign fall     = ~sig & delayed_sig;
  // armed_q masks the first cycle after reset, when delayed_sig is not yet valid.
  assign edge_req = armed_q & ((rise & rise_en) | (fall & fall_en));
  assign pop      = ev_valid & ev_ready;
  assign push     = edge_req & (~fifo_full | pop);
  assign drop     = edge_req & ~push;

  always_comb begin
    wdata                       = '0;
    wdata[TB]                   = rise ? EDGE_RISE : EDGE_FALL;
    wdata[EV_TS_LSB +: TS_WIDTH] = ts_q;
  end

  always_comb begin
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    if (clr_stats) begin
      overflow_d   = 1'b0;
      drop_count_d = '0;
    end
    // A drop in the same cycle as a clear still gets counted.
    if (drop) begin
      overflow_d = 1'b1;
      if (clr_stats)
        drop_count_d = DROP_WIDTH'(1);
      else if (drop_count_q != '1)
        drop_count_d = drop_count_q + DROP_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      armed_q      <= 1'b0;
      ts_q         <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      armed_q      <= 1'b1;
      ts_q         <= ts_q + TS_WIDTH'(1);
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  sync_fifo_fwft #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (ev_data),
    .count (ev_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign ev_valid   = ~fifo_empty;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule
